// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Serves CPU memory-stage loads/stores and issues word transactions to backing memory.
module dcache_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
);

  localparam int unsigned Lines   = 1 << INDEX_BITS;
  localparam int unsigned TagBits = ADDR_WIDTH - INDEX_BITS - 2;
  localparam int unsigned WBits   = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {StIdle, StRdMiss, StWrThru, StResp} state_e;

  state_e                  r_state;
  state_e                  w_state_d;
  logic [Lines-1:0]        r_valid;
  logic [TagBits-1:0]      r_tag  [Lines];
  logic [DATA_WIDTH-1:0]   r_data [Lines];
  logic [WBits-1:0]        r_waddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_resp;
  logic [31:0]             r_hit_cnt;
  logic [31:0]             r_miss_cnt;

  logic [INDEX_BITS-1:0]   w_idx;
  logic [TagBits-1:0]      w_tag;
  logic                    w_hit;
  logic [INDEX_BITS-1:0]   w_l_idx;
  logic [TagBits-1:0]      w_l_tag;
  logic                    w_l_hit;
  logic                    w_idle_req;
  logic                    w_load_hit;
  logic                    w_load_miss;
  logic [1:0]              w_unused_byte_off;

  assign w_unused_byte_off = addr_i[1:0];

  assign w_idx   = addr_i[INDEX_BITS+1:2];
  assign w_tag   = addr_i[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_l_idx = r_waddr[INDEX_BITS-1:0];
  assign w_l_tag = r_waddr[WBits-1:INDEX_BITS];
  assign w_l_hit = r_valid[w_l_idx] && (r_tag[w_l_idx] == w_l_tag);

  assign w_idle_req  = (r_state == StIdle) && req_i;
  assign w_load_hit  = w_idle_req && !we_i && w_hit;
  assign w_load_miss = w_idle_req && !we_i && !w_hit;

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;

  always_comb begin
    w_state_d   = r_state;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    rdata_o     = '0;
    unique case (r_state)
      StIdle: begin
        if (req_i) begin
          if (we_i) begin
            stall_o   = 1'b1;
            w_state_d = StWrThru;
          end else if (w_hit) begin
            rdata_o = r_data[w_idx];
          end else begin
            stall_o   = 1'b1;
            w_state_d = StRdMiss;
          end
        end
      end
      StRdMiss: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {r_waddr, 2'b00};
        if (mem_ack_i) w_state_d = StResp;
      end
      StWrThru: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {r_waddr, 2'b00};
        mem_wdata_o = r_wdata;
        if (mem_ack_i) w_state_d = StResp;
      end
      StResp: begin
        rdata_o   = r_resp;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= StIdle;
      r_valid    <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_resp     <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      // Response register is cleared on entry so stores answer with zero.
      if (w_idle_req && (we_i || !w_hit)) begin
        r_waddr <= addr_i[ADDR_WIDTH-1:2];
        r_wdata <= wdata_i;
        r_resp  <= '0;
      end
      if ((r_state == StRdMiss) && mem_ack_i) begin
        r_valid[w_l_idx] <= 1'b1;
        r_resp           <= mem_rdata_i;
      end
      if (w_load_hit && (r_hit_cnt != 32'hFFFF_FFFF)) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_load_miss && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  // Tag/data need no reset: the valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if ((r_state == StRdMiss) && mem_ack_i) begin
      r_tag[w_l_idx]  <= w_l_tag;
      r_data[w_l_idx] <= mem_rdata_i;
    end else if ((r_state == StWrThru) && mem_ack_i && w_l_hit) begin
      r_data[w_l_idx] <= r_wdata;
    end
  end

endmodule
